mat_mult_sched: RTL and testbench
=================================

Name: mat_mult_sched

Overview:
Sequencing controller for matrix multiplication on a single shared dot-product engine. On `start`, it walks every output element (i,j) of an N_ROWS x N_COLUMNS result in row-major order. For each element it issues one job to the engine (row index of mat1, column index of mat2), waits for the engine result, and writes it to the result store through a ready/valid write port. It reports `busy` and `done` to the top-level controller and supports abort.

Parameters:
- N_ROWS, 3, rows of result matrix (row count of mat1); must be >= 1
- N_COLUMNS, 2, columns of result matrix (column count of mat2); must be >= 1
- DATA_WIDTH, 32, width of the engine result and of write data
- ROW_W, $clog2(N_ROWS) with a minimum of 1, width of row indices
- COL_W, $clog2(N_COLUMNS) with a minimum of 1, width of column indices

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a full multiply; sampled only in IDLE
- abort  in  1  synchronous cancel of the operation in progress
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last element is written
- aborted  out  1  one-cycle pulse when an abort takes effect
- dp_start  out  1  job request to the engine
- dp_row  out  ROW_W  mat1 row index for the job
- dp_col  out  COL_W  mat2 column index for the job
- dp_ready  in  1  engine accepts the job when dp_start && dp_ready
- dp_valid  in  1  engine result valid
- dp_result  in  DATA_WIDTH  engine result
- wr_en  out  1  result write request
- wr_row  out  ROW_W  result row index
- wr_col  out  COL_W  result column index
- wr_data  out  DATA_WIDTH  result value
- wr_ready  in  1  store accepts the write when wr_en && wr_ready
- proto_err  out  1  sticky flag: dp_valid seen outside WAIT; cleared by reset or by an accepted start

Behaviour:
- **Reset (reset = 0, asynchronous):**
  - state = IDLE.
  - Row and column counters = 0.
  - All outputs = 0, including proto_err and the captured result register.
- **States:** IDLE, ISSUE, WAIT, WRITE, FINISH.
- **IDLE:**
  - If start = 1: clear counters and proto_err, then go to ISSUE on the next edge.
  - Otherwise remain in IDLE.
- **ISSUE:**
  - dp_start = 1; dp_row and dp_col = current counters.
  - If dp_ready = 1, go to WAIT. Otherwise hold dp_start and indices stable (no retraction).
- **WAIT:**
  - dp_start = 0.
  - If dp_valid = 1, capture dp_result into an internal register and go to WRITE.
- **WRITE:**
  - wr_en = 1; wr_row and wr_col = counters; wr_data = captured value. All held stable until wr_ready = 1.
  - On acceptance:
    - if the counters address the last element (N_ROWS-1, N_COLUMNS-1), go to FINISH;
    - otherwise advance row-major (col+1; when col wraps at N_COLUMNS-1, col = 0 and row+1), then go to ISSUE.
- **FINISH:**
  - done = 1 for exactly one cycle, then go to IDLE.
  - Counters keep their final values until the next start.
- **Latency:**
  - Each element takes at least 3 cycles (ISSUE, WAIT, WRITE), with dp_ready = 1, dp_valid one cycle after acceptance, and wr_ready = 1.
  - Minimum start-to-done: done is high in cycle 3*N_ROWS*N_COLUMNS + 1 after the edge that samples start.
- **Abort** (any state other than IDLE):
  - On the next edge: state = IDLE, aborted = 1 for one cycle, no done.
  - dp_start and wr_en drop in that cycle.
  - A dp_result still in flight is ignored and sets no error.
  - Abort has priority over all other transitions in the same cycle. Abort in IDLE has no effect.
- **start ignored:** start is ignored while busy = 1, and ignored in the same cycle as an abort.
- **Protocol error:** dp_valid = 1 in any state other than WAIT sets proto_err, except in the cycle after an abort. The state machine is unaffected.
- **Outputs:** all outputs are registered, or decoded from the state register only; there are no combinational paths from inputs to outputs.

Test Plan:
1. **Basic multiply.**
   - Stimulus: N_ROWS = 3, N_COLUMNS = 2. Engine model computes mat1 = {{1,2},{3,4},{5,6}} times {{1,2},{3,4}} with latency 1; dp_ready = wr_ready = 1.
   - Required: writes in order (0,0)=7, (0,1)=10, (1,0)=15, (1,1)=22, (2,0)=23, (2,1)=34.
   - Required: done is high exactly 19 cycles after start; busy is low the cycle after done.
2. **Back-pressure.**
   - Stimulus: dp_ready low for 3 cycles on every job; engine latency 4; wr_ready low for 2 cycles on every write.
   - Required: same 6 values, each written once.
   - Required: dp_start, dp_row, dp_col, wr_en and wr_data held stable while stalled; no duplicate jobs.
3. **Abort mid-run.**
   - Stimulus: assert abort while in WAIT for element (1,0), with that result arriving the cycle after.
   - Required: aborted pulses once; no done; no wr_en for (1,0); proto_err stays 0.
   - Stimulus: restart.
   - Required: full 6-element result, correct values.
4. **Asynchronous reset mid-operation.**
   - Stimulus: drive reset low between clock edges during WRITE.
   - Required: all outputs 0 immediately, with no clock edge needed.
   - Required: after release, start produces a correct full run.
5. **start while busy, spurious valid.**
   - Stimulus: pulse start in ISSUE.
   - Required: no restart; counters unaffected.
   - Stimulus: inject dp_valid in WRITE.
   - Required: proto_err = 1 and stays 1 until the next accepted start; wr_data unchanged.
6. **Degenerate size.**
   - Stimulus: N_ROWS = N_COLUMNS = 1; engine returns 42.
   - Required: a single write (0,0)=42; done high 4 cycles after start.

Source files
------------

// File: rtl/mat_mult_sched.sv
// rtl/mat_mult_sched.sv - row-major matrix multiply sequencer driving a shared dot-product engine
// Purpose: walks every result element (i,j), issues one engine job per element, waits for the
//          engine result and writes it to the result store; reports busy/done, supports abort.
// Ports:
//   clk, reset          - rising-edge clock, asynchronous active-low reset
//   start, abort        - begin a full multiply (IDLE only) / cancel the run in progress
//   busy, done, aborted - status: not IDLE, one-cycle completion pulse, one-cycle abort pulse
//   dp_start/dp_row/dp_col/dp_ready       - engine job request handshake
//   dp_valid/dp_result                    - engine result
//   wr_en/wr_row/wr_col/wr_data/wr_ready  - result store write handshake
//   proto_err           - sticky: engine result seen outside WAIT
module mat_mult_sched #(
    parameter int N_ROWS     = 3,
    parameter int N_COLUMNS  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ROW_W      = (N_ROWS > 1) ? $clog2(N_ROWS) : 1,
    parameter int COL_W      = (N_COLUMNS > 1) ? $clog2(N_COLUMNS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic                  dp_start,
    output logic [ROW_W-1:0]      dp_row,
    output logic [COL_W-1:0]      dp_col,
    input  logic                  dp_ready,
    input  logic                  dp_valid,
    input  logic [DATA_WIDTH-1:0] dp_result,
    output logic                  wr_en,
    output logic [ROW_W-1:0]      wr_row,
    output logic [COL_W-1:0]      wr_col,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_ready,
    output logic                  proto_err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_WRITE  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(N_COLUMNS - 1);

    state_t                state_q, state_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  aborted_q, aborted_d;
    logic                  proto_err_q, proto_err_d;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        data_d      = data_q;
        aborted_d   = 1'b0;
        proto_err_d = proto_err_q;

        // Abort outranks every other transition; in IDLE it only blocks a same-cycle start.
        if (abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            aborted_d = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        row_d       = '0;
                        col_d       = '0;
                        proto_err_d = 1'b0;
                        state_d     = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (dp_ready) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dp_valid) begin
                        data_d  = dp_result;
                        state_d = S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (wr_ready) begin
                        if ((row_q == LAST_ROW) && (col_q == LAST_COL)) begin
                            state_d = S_FINISH;
                        end else begin
                            state_d = S_ISSUE;
                            if (col_q == LAST_COL) begin
                                col_d = '0;
                                row_d = row_q + ROW_W'(1);
                            end else begin
                                col_d = col_q + COL_W'(1);
                            end
                        end
                    end
                end
                S_FINISH: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // A result still in flight when an abort landed arrives in the cycle flagged by
        // aborted_q; that one is expected and must not raise the sticky error.
        if (dp_valid && (state_q != S_WAIT) && !aborted_q) begin
            proto_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            data_q      <= '0;
            aborted_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            data_q      <= data_d;
            aborted_q   <= aborted_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Every output comes straight from a flop or a state decode: no input-to-output paths.
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FINISH);
    assign aborted   = aborted_q;
    assign dp_start  = (state_q == S_ISSUE);
    assign dp_row    = row_q;
    assign dp_col    = col_q;
    assign wr_en     = (state_q == S_WRITE);
    assign wr_row    = row_q;
    assign wr_col    = col_q;
    assign wr_data   = data_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_mat_mult_sched.sv
// tb/tb_mat_mult_sched.sv - directed self-checking bench for mat_mult_sched (3x2 and 1x1 instances)
module tb_mat_mult_sched;

    localparam int DW = 32;
    localparam logic [31:0] EXP [6] = '{32'd7, 32'd10, 32'd15, 32'd22, 32'd23, 32'd34};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 3x2 instance
    logic          rst_n, start, abort;
    logic          busy, done, aborted, dp_start, dp_ready, dp_valid, wr_en, wr_ready, proto_err;
    logic [1:0]    dp_row, wr_row;
    logic          dp_col, wr_col;
    logic [DW-1:0] dp_result, wr_data;

    // 1x1 instance
    logic          start1, abort1;
    logic          busy1, done1, aborted1, dp_start1, dp_ready1, dp_valid1, wr_en1, wr_ready1, proto_err1;
    logic          dp_row1, dp_col1, wr_row1, wr_col1;
    logic [DW-1:0] dp_result1, wr_data1;

    mat_mult_sched #(.N_ROWS(3), .N_COLUMNS(2), .DATA_WIDTH(DW)) u_dut (
        .clk(clk), .reset(rst_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .aborted(aborted),
        .dp_start(dp_start), .dp_row(dp_row), .dp_col(dp_col), .dp_ready(dp_ready),
        .dp_valid(dp_valid), .dp_result(dp_result),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .wr_ready(wr_ready),
        .proto_err(proto_err)
    );

    mat_mult_sched #(.N_ROWS(1), .N_COLUMNS(1), .DATA_WIDTH(DW)) u_dut1 (
        .clk(clk), .reset(rst_n), .start(start1), .abort(abort1),
        .busy(busy1), .done(done1), .aborted(aborted1),
        .dp_start(dp_start1), .dp_row(dp_row1), .dp_col(dp_col1), .dp_ready(dp_ready1),
        .dp_valid(dp_valid1), .dp_result(dp_result1),
        .wr_en(wr_en1), .wr_row(wr_row1), .wr_col(wr_col1), .wr_data(wr_data1), .wr_ready(wr_ready1),
        .proto_err(proto_err1)
    );

    int n_checks, n_pass;

    // Engine / store model configuration (written by tests only)
    int cfg_dp_stall, cfg_lat, cfg_wr_stall;
    int inject_req;

    // Model state and logs (written by the model only)
    int stall_cnt, wstall_cnt, pend, inject_ack;
    logic [31:0] pend_val;
    int jobs = 0, wr_count = 0, done_count = 0, aborted_count = 0, stab_err = 0;
    logic [1:0]  log_row  [128];
    logic        log_col  [128];
    logic [31:0] log_data [128];
    logic        prev_dp_start, prev_dp_ready, prev_wr_en, prev_wr_ready;
    logic [2:0]  prev_dp_idx;
    logic [34:0] prev_w;

    // mat1 = {{1,2},{3,4},{5,6}}, mat2 = {{1,2},{3,4}}
    function automatic logic [31:0] engine_calc(input int r, input int c);
        int a0, a1;
        a0 = 2 * r + 1;
        a1 = 2 * r + 2;
        return 32'(a0 * (1 + c) + a1 * (3 + c));
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            dp_ready = 1'b0; dp_valid = 1'b0; dp_result = '0; wr_ready = 1'b0;
            pend = 0; stall_cnt = 0; wstall_cnt = 0; inject_ack = inject_req;
            prev_dp_start = 1'b0; prev_dp_ready = 1'b0; prev_wr_en = 1'b0; prev_wr_ready = 1'b0;
            prev_dp_idx = '0; prev_w = '0;
        end else begin
            if (prev_dp_start && !prev_dp_ready && !aborted)
                if (!dp_start || ({dp_row, dp_col} !== prev_dp_idx)) stab_err++;
            if (prev_wr_en && !prev_wr_ready && !aborted)
                if (!wr_en || ({wr_row, wr_col, wr_data} !== prev_w)) stab_err++;
            if (done) done_count++;
            if (aborted) aborted_count++;

            dp_valid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    dp_valid  = 1'b1;
                    dp_result = pend_val;
                end
            end
            if (inject_req != inject_ack) begin
                inject_ack = inject_req;
                dp_valid   = 1'b1;
                dp_result  = 32'hDEAD_BEEF;
            end

            if (dp_start) begin
                if (stall_cnt < cfg_dp_stall) begin
                    dp_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    dp_ready  = 1'b1;
                    stall_cnt = 0;
                    jobs++;
                    pend      = cfg_lat;
                    pend_val  = engine_calc(int'(dp_row), int'(dp_col));
                end
            end else begin
                dp_ready  = 1'b0;
                stall_cnt = 0;
            end

            if (wr_en) begin
                if (wstall_cnt < cfg_wr_stall) begin
                    wr_ready = 1'b0;
                    wstall_cnt++;
                end else begin
                    wr_ready   = 1'b1;
                    wstall_cnt = 0;
                    if (wr_count < 128) begin
                        log_row[wr_count]  = wr_row;
                        log_col[wr_count]  = wr_col;
                        log_data[wr_count] = wr_data;
                    end
                    wr_count++;
                end
            end else begin
                wr_ready   = 1'b0;
                wstall_cnt = 0;
            end

            prev_dp_start = dp_start; prev_dp_ready = dp_ready; prev_dp_idx = {dp_row, dp_col};
            prev_wr_en = wr_en; prev_wr_ready = wr_ready; prev_w = {wr_row, wr_col, wr_data};
        end
    end

    // Stimulus helpers (no checks inside): wait for done, or pulse start and wait for done.
    task automatic wait_done(input int s, output bit ok, output int dcyc);
        ok = 1'b0;
        dcyc = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                ok = 1'b1;
                dcyc = cyc - s;
            end
        end
    endtask

    task automatic run_wait(output bit ok, output int dcyc);
        int s;
        start = 1'b1;
        s = cyc;
        wait_done(s, ok, dcyc);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_checks++;
        if ({busy, done, aborted, dp_start, dp_row, dp_col, wr_en, wr_row, wr_col, wr_data, proto_err} !== '0)
            $display("FAIL reset_outputs: got busy=%b dp_start=%b wr_en=%b wr_data=%h", busy, dp_start, wr_en, wr_data);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if ({busy1, done1, aborted1, dp_start1, dp_row1, dp_col1, wr_en1, wr_row1, wr_col1, wr_data1, proto_err1} !== '0)
            $display("FAIL reset_outputs_1x1: got busy=%b wr_data=%h", busy1, wr_data1);
        else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL idle_after_reset: busy=%b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_basic();
        bit ok; int dcyc, wb, jb;
        cfg_dp_stall = 0; cfg_lat = 1; cfg_wr_stall = 0;
        wb = wr_count; jb = jobs;
        run_wait(ok, dcyc);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL basic_done_seen: timeout");
        else n_pass++;
        n_checks++;
        if (dcyc != 19) $display("FAIL basic_latency: done after %0d cycles, want 19", dcyc);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if ({busy, done} !== 2'b00) $display("FAIL basic_busy_after_done: busy=%b done=%b want 0 0", busy, done);
        else n_pass++;
        n_checks++;
        if (wr_count - wb != 6) $display("FAIL basic_write_count: %0d want 6", wr_count - wb);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if ({log_row[wb+i], log_col[wb+i], log_data[wb+i]} !== {2'(i / 2), 1'(i % 2), EXP[i]})
                $display("FAIL basic_write_%0d: (%0d,%0d)=%0d want (%0d,%0d)=%0d", i,
                         log_row[wb+i], log_col[wb+i], log_data[wb+i], i / 2, i % 2, EXP[i]);
            else n_pass++;
        end
        n_checks++;
        if ((jobs - jb != 6) || (proto_err !== 1'b0))
            $display("FAIL basic_jobs_err: jobs=%0d proto_err=%b want 6 0", jobs - jb, proto_err);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        bit ok; int dcyc, wb, jb, sb;
        cfg_dp_stall = 3; cfg_lat = 4; cfg_wr_stall = 2;
        wb = wr_count; jb = jobs; sb = stab_err;
        run_wait(ok, dcyc);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL bp_done_seen: timeout");
        else n_pass++;
        n_checks++;
        if (wr_count - wb != 6) $display("FAIL bp_write_count: %0d want 6", wr_count - wb);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if ({log_row[wb+i], log_col[wb+i], log_data[wb+i]} !== {2'(i / 2), 1'(i % 2), EXP[i]})
                $display("FAIL bp_write_%0d: (%0d,%0d)=%0d want (%0d,%0d)=%0d", i,
                         log_row[wb+i], log_col[wb+i], log_data[wb+i], i / 2, i % 2, EXP[i]);
            else n_pass++;
        end
        n_checks++;
        if (jobs - jb != 6) $display("FAIL bp_job_count: %0d want 6", jobs - jb);
        else n_pass++;
        n_checks++;
        if (stab_err != sb) $display("FAIL bp_stable_while_stalled: %0d violations want 0", stab_err - sb);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        bit ok, found; int dcyc, wb, db, ab;
        cfg_dp_stall = 0; cfg_lat = 2; cfg_wr_stall = 0;
        wb = wr_count; db = done_count; ab = aborted_count;
        start = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (dp_start && dp_row == 2'd1 && dp_col == 1'b0) found = 1'b1;
        end
        n_checks++;
        if (!found) $display("FAIL abort_find_issue_1_0: timeout");
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if ({busy, dp_start, wr_en} !== 3'b100) $display("FAIL abort_in_wait: busy/dp_start/wr_en=%b want 100", {busy, dp_start, wr_en});
        else n_pass++;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        n_checks++;
        if ({aborted, busy, dp_start, wr_en, done} !== 5'b10000)
            $display("FAIL abort_effect: aborted/busy/dp_start/wr_en/done=%b want 10000", {aborted, busy, dp_start, wr_en, done});
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if ({aborted, proto_err} !== 2'b00) $display("FAIL abort_pulse_err: aborted=%b proto_err=%b want 0 0", aborted, proto_err);
        else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ((aborted_count - ab != 1) || (done_count - db != 0) || (wr_count - wb != 2) || (proto_err !== 1'b0))
            $display("FAIL abort_summary: aborted=%0d done=%0d writes=%0d proto_err=%b want 1 0 2 0",
                     aborted_count - ab, done_count - db, wr_count - wb, proto_err);
        else n_pass++;
        cfg_lat = 1;
        wb = wr_count;
        run_wait(ok, dcyc);
        n_checks++;
        if ((ok !== 1'b1) || (dcyc != 19)) $display("FAIL abort_restart_done: ok=%b cycles=%0d want 1 19", ok, dcyc);
        else n_pass++;
        n_checks++;
        if (wr_count - wb != 6) $display("FAIL abort_restart_count: %0d want 6", wr_count - wb);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if ({log_row[wb+i], log_col[wb+i], log_data[wb+i]} !== {2'(i / 2), 1'(i % 2), EXP[i]})
                $display("FAIL abort_restart_write_%0d: (%0d,%0d)=%0d want %0d", i,
                         log_row[wb+i], log_col[wb+i], log_data[wb+i], EXP[i]);
            else n_pass++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        bit ok, found; int dcyc, wb;
        cfg_dp_stall = 0; cfg_lat = 1; cfg_wr_stall = 0;
        start = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (wr_en && wr_row == 2'd1 && wr_col == 1'b1) found = 1'b1;
        end
        n_checks++;
        if (!found || wr_data !== 32'd22) $display("FAIL arst_find_write_1_1: found=%b wr_data=%0d want 1 22", found, wr_data);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, aborted, dp_start, dp_row, dp_col, wr_en, wr_row, wr_col, wr_data, proto_err} !== '0)
            $display("FAIL arst_immediate: busy=%b wr_en=%b wr_row=%0d wr_data=%h want all 0", busy, wr_en, wr_row, wr_data);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        wb = wr_count;
        run_wait(ok, dcyc);
        n_checks++;
        if ((ok !== 1'b1) || (dcyc != 19) || (wr_count - wb != 6))
            $display("FAIL arst_rerun: ok=%b cycles=%0d writes=%0d want 1 19 6", ok, dcyc, wr_count - wb);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if ({log_row[wb+i], log_col[wb+i], log_data[wb+i]} !== {2'(i / 2), 1'(i % 2), EXP[i]})
                $display("FAIL arst_rerun_write_%0d: (%0d,%0d)=%0d want %0d", i,
                         log_row[wb+i], log_col[wb+i], log_data[wb+i], EXP[i]);
            else n_pass++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_busy_spurious();
        bit ok, found; int dcyc, wb, jb, s;
        cfg_dp_stall = 0; cfg_lat = 1; cfg_wr_stall = 0;
        wb = wr_count; jb = jobs;
        start = 1'b1;
        s = cyc;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (dp_start && dp_row == 2'd0 && dp_col == 1'b1) found = 1'b1;
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (!found || {busy, dp_start, dp_row, dp_col} !== 5'b10001)
            $display("FAIL busy_start_ignored: found=%b busy=%b dp_start=%b row=%0d col=%0d want WAIT at (0,1)",
                     found, busy, dp_start, dp_row, dp_col);
        else n_pass++;
        wait_done(s, ok, dcyc);
        n_checks++;
        if ((ok !== 1'b1) || (dcyc != 19) || (jobs - jb != 6) || (wr_count - wb != 6))
            $display("FAIL busy_start_run: ok=%b cycles=%0d jobs=%0d writes=%0d want 1 19 6 6",
                     ok, dcyc, jobs - jb, wr_count - wb);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if ({log_row[wb+i], log_col[wb+i], log_data[wb+i]} !== {2'(i / 2), 1'(i % 2), EXP[i]})
                $display("FAIL busy_start_write_%0d: (%0d,%0d)=%0d want %0d", i,
                         log_row[wb+i], log_col[wb+i], log_data[wb+i], EXP[i]);
            else n_pass++;
        end
        @(posedge clk); #1;

        cfg_wr_stall = 2;
        wb = wr_count;
        start = 1'b1;
        s = cyc;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (wr_en) found = 1'b1;
        end
        inject_req++;
        @(posedge clk); #1;
        n_checks++;
        if (proto_err !== 1'b1) $display("FAIL spurious_sets_err: proto_err=%b want 1", proto_err);
        else n_pass++;
        n_checks++;
        if (!found || {wr_en, wr_row, wr_col, wr_data} !== {1'b1, 2'd0, 1'b0, 32'd7})
            $display("FAIL spurious_wr_data_held: wr_en=%b wr_data=%h want 1 7", wr_en, wr_data);
        else n_pass++;
        wait_done(s, ok, dcyc);
        @(posedge clk); #1;
        n_checks++;
        if ((ok !== 1'b1) || (proto_err !== 1'b1) || (busy !== 1'b0))
            $display("FAIL spurious_err_sticky: ok=%b proto_err=%b busy=%b want 1 1 0", ok, proto_err, busy);
        else n_pass++;
        n_checks++;
        if ((wr_count - wb != 6) || (log_data[wb] !== 32'd7) || (log_data[wb+5] !== 32'd34))
            $display("FAIL spurious_run_values: writes=%0d first=%0d last=%0d want 6 7 34",
                     wr_count - wb, log_data[wb], log_data[wb+5]);
        else n_pass++;
        cfg_wr_stall = 0;
        start = 1'b1;
        s = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if ({proto_err, busy} !== 2'b01) $display("FAIL start_clears_err: proto_err=%b busy=%b want 0 1", proto_err, busy);
        else n_pass++;
        wait_done(s, ok, dcyc);
        n_checks++;
        if ((ok !== 1'b1) || (dcyc != 19)) $display("FAIL clear_run_done: ok=%b cycles=%0d want 1 19", ok, dcyc);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_degenerate();
        int nwr;
        nwr = 0;
        dp_ready1 = 1'b1; wr_ready1 = 1'b1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        n_checks++;
        if ({busy1, dp_start1, dp_row1, dp_col1} !== 4'b1100) $display("FAIL deg_issue: busy=%b dp_start=%b want 1 1", busy1, dp_start1);
        else n_pass++;
        @(posedge clk); #1;
        dp_valid1 = 1'b1; dp_result1 = 32'd42;
        if (wr_en1) nwr++;
        @(posedge clk); #1;
        dp_valid1 = 1'b0; dp_result1 = '0;
        n_checks++;
        if ({wr_en1, wr_row1, wr_col1, wr_data1} !== {1'b1, 1'b0, 1'b0, 32'd42})
            $display("FAIL deg_write: wr_en=%b (%0d,%0d)=%0d want 1 (0,0)=42", wr_en1, wr_row1, wr_col1, wr_data1);
        else n_pass++;
        if (wr_en1) nwr++;
        @(posedge clk); #1;
        n_checks++;
        if ({done1, busy1, wr_en1} !== 3'b110) $display("FAIL deg_done_cycle4: done=%b busy=%b wr_en=%b want 1 1 0", done1, busy1, wr_en1);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if ({done1, busy1, proto_err1} !== 3'b000 || nwr != 1)
            $display("FAIL deg_idle: done=%b busy=%b proto_err=%b writes=%0d want 0 0 0 1", done1, busy1, proto_err1, nwr);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        start1 = 1'b0; abort1 = 1'b0;
        dp_ready1 = 1'b0; dp_valid1 = 1'b0; dp_result1 = '0; wr_ready1 = 1'b0;
        cfg_dp_stall = 0; cfg_lat = 1; cfg_wr_stall = 0; inject_req = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_abort();
        test_async_reset();
        test_start_busy_spurious();
        test_degenerate();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
